// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game sequencer for Breakout.
// Owns the ball position and direction, the lives and score counters, and
// the IDLE/PLAY/LOST/OVER state machine. All game state advances on
// frame_tick only. Between ticks, serve and brick_hit are latched so that
// short pulses are not missed.
//
// Ports:
//   CLOCK_50    system clock
//   reset_n     asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame (start of vertical blanking)
//   serve       debounced serve button pulse
//   paddle_x    left column of the paddle (paddle spans paddle_x..paddle_x+64)
//   brick_hit   scanned ball overlaps a live brick
//   ball_x      ball left column (ball is 4x4)
//   ball_y      ball top row
//   state       IDLE=0, PLAY=1, LOST=2, OVER=3
//   lives       remaining lives
//   score       bricks hit, saturating at 1023
//
// state | meaning
// IDLE  | ball rides the paddle, waiting for serve
// PLAY  | ball in flight, walls/paddle/bricks resolved every frame
// LOST  | ball missed, frozen for LOST_FRAMES frames
// OVER  | no lives left, serve restarts the game
module breakout_game_ctrl #(
  parameter int SPEED       = 2,
  parameter int LIVES       = 3,
  parameter int LOST_FRAMES = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle_x,
  input  logic       brick_hit,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [1:0] state,
  output logic [2:0] lives,
  output logic [9:0] score
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, LOST = 2'd2, OVER = 2'd3} state_t;

  localparam logic signed [10:0] STEP = 11'(SPEED);

  state_t     st;
  logic       dx, dy;
  logic       serve_pend, hit_pend;
  logic [7:0] frame_cnt;

  logic              dy_eff;
  logic signed [10:0] nx, ny;
  logic signed [11:0] bx, by, px, ny_w;
  logic              on_paddle;

  assign state = st;

  // A pending brick hit flips the vertical direction before the step is taken.
  always_comb begin
    dy_eff = hit_pend ? ~dy : dy;
    nx     = dx ? (signed'({1'b0, ball_x}) + STEP) : (signed'({1'b0, ball_x}) - STEP);
    ny     = dy_eff ? (signed'({2'b00, ball_y}) + STEP) : (signed'({2'b00, ball_y}) - STEP);
    bx     = signed'({2'b00, ball_x});
    by     = signed'({3'b000, ball_y});
    px     = signed'({2'b00, paddle_x});
    ny_w   = {ny[10], ny};
    // Catch only when the ball bottom crosses the paddle top on this step.
    on_paddle = dy_eff
             && (by + 12'sd3 < 12'sd440)
             && (ny_w + 12'sd3 >= 12'sd440)
             && (bx + 12'sd3 >= px)
             && (bx <= px + 12'sd64);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      lives      <= 3'(LIVES);
      score      <= 10'd0;
      ball_x     <= 10'd295;
      ball_y     <= 9'd436;
      dx         <= 1'b1;
      dy         <= 1'b0;
      serve_pend <= 1'b0;
      hit_pend   <= 1'b0;
      frame_cnt  <= 8'd0;
    end else if (frame_tick) begin
      // Pulses coinciding with the tick are dropped along with the flags.
      serve_pend <= 1'b0;
      hit_pend   <= 1'b0;
      case (st)
        IDLE: begin
          ball_x <= paddle_x + 10'd30;
          ball_y <= 9'd436;
          dx     <= 1'b1;
          dy     <= 1'b0;
          if (serve_pend) st <= PLAY;
        end
        PLAY: begin
          if (hit_pend && score != 10'd1023) score <= score + 10'd1;
          if (nx < 11'sd40) begin
            ball_x <= 10'd40;
            dx     <= 1'b1;
          end else if (nx > 11'sd586) begin
            ball_x <= 10'd586;
            dx     <= 1'b0;
          end else begin
            ball_x <= nx[9:0];
          end
          dy <= dy_eff;
          if (ny < 11'sd30) begin
            ball_y <= 9'd30;
            dy     <= 1'b1;
          end else if (on_paddle) begin
            ball_y <= 9'd436;
            dy     <= 1'b0;
          end else if (ny > 11'sd476) begin
            if (lives != 3'd0) lives <= lives - 3'd1;
            frame_cnt <= 8'(LOST_FRAMES);
            st        <= LOST;
          end else begin
            ball_y <= ny[8:0];
          end
        end
        LOST: begin
          if (frame_cnt <= 8'd1) begin
            frame_cnt <= 8'd0;
            st        <= (lives == 3'd0) ? OVER : IDLE;
          end else begin
            frame_cnt <= frame_cnt - 8'd1;
          end
        end
        OVER: begin
          if (serve_pend) begin
            lives <= 3'(LIVES);
            score <= 10'd0;
            st    <= IDLE;
          end
        end
      endcase
    end else begin
      if (serve) serve_pend <= 1'b1;
      if (brick_hit && st == PLAY) hit_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl. The ball is steered through a
// hand-traced trajectory (paddle catch, right/top/left walls, misses),
// then through game over, restart and an asynchronous reset mid-play.
module tb_breakout_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_x;
  logic       brick_hit;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [1:0] state;
  logic [2:0] lives;
  logic [9:0] score;

  int n_checks = 0;
  int n_errors = 0;

  breakout_game_ctrl dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .serve     (serve),
    .paddle_x  (paddle_x),
    .brick_hit (brick_hit),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .state     (state),
    .lives     (lives),
    .score     (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, ".x"}, int'(ball_x), x);
    check({tag, ".y"}, int'(ball_y), y);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
  endtask

  task automatic hold_hit(input int n);
    @(negedge clk) brick_hit = 1'b1;
    repeat (n) @(negedge clk);
    brick_hit = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    serve      = 1'b0;
    brick_hit  = 1'b0;
    paddle_x   = 10'd265;
    repeat (3) @(negedge clk);
    check("rst.state", int'(state), 0);
    check("rst.lives", int'(lives), 3);
    check("rst.score", int'(score), 0);
    check_ball("rst.ball", 295, 436);
    reset_n = 1'b1;

    tick();
    check("idle.state", int'(state), 0);
    check_ball("idle.ball", 295, 436);

    pulse_serve();
    tick();
    check("serve.state", int'(state), 1);
    check_ball("serve.ball", 295, 436);
    tick();
    check_ball("step1", 297, 434);

    // Multi-cycle brick hit counts once and turns the ball downward.
    hold_hit(5);
    tick();
    check_ball("brick", 299, 436);
    check("brick.score", int'(score), 1);

    tick();
    check_ball("catch", 301, 436);
    tick();
    check_ball("after_catch", 303, 434);

    run(141);
    check_ball("pre_right", 585, 152);
    tick();
    check_ball("right_wall", 586, 150);
    tick();
    check_ball("after_right", 584, 148);

    run(59);
    check_ball("pre_top", 466, 30);
    tick();
    check_ball("top_wall", 464, 30);

    pulse_serve();
    tick();
    check("serve_in_play.state", int'(state), 1);
    check_ball("after_top", 462, 32);

    // brick_hit only on the tick cycle is dropped.
    @(negedge clk) begin frame_tick = 1'b1; brick_hit = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; brick_hit = 1'b0; end
    check_ball("hit_on_tick", 460, 34);
    check("hit_on_tick.score", int'(score), 1);
    tick();
    check_ball("hit_on_tick2", 458, 36);

    run(200);
    check_ball("pre_paddle", 58, 436);
    tick();
    check_ball("paddle_miss_x", 56, 438);
    run(8);
    check_ball("pre_left", 40, 454);
    tick();
    check_ball("left_wall", 40, 456);
    tick();
    check_ball("after_left", 42, 458);
    run(9);
    check_ball("pre_miss1", 60, 476);
    check("pre_miss1.state", int'(state), 1);
    tick();
    check("miss1.state", int'(state), 2);
    check("miss1.lives", int'(lives), 2);

    run(59);
    check("lost59.state", int'(state), 2);
    check("lost.frozen_y", int'(ball_y), 476);
    tick();
    check("lost60.state", int'(state), 0);
    check("lost60.lives", int'(lives), 2);

    paddle_x = 10'd100;
    tick();
    check("ride.state", int'(state), 0);
    check_ball("ride", 130, 436);

    pulse_serve();
    tick();
    check("serve2.state", int'(state), 1);
    paddle_x = 10'd400;
    hold_hit(3);
    tick();
    check_ball("miss2_start", 132, 438);
    check("miss2.score", int'(score), 2);
    run(19);
    check_ball("pre_miss2", 170, 476);
    tick();
    check("miss2.state", int'(state), 2);
    check("miss2.lives", int'(lives), 1);
    run(60);
    check("miss2_end.state", int'(state), 0);

    paddle_x = 10'd100;
    pulse_serve();
    tick();
    check_ball("serve3", 130, 436);
    paddle_x = 10'd400;
    hold_hit(2);
    tick();
    check("miss3.score", int'(score), 3);
    run(20);
    check("miss3.state", int'(state), 2);
    check("miss3.lives", int'(lives), 0);
    run(59);
    check("over59.state", int'(state), 2);
    tick();
    check("over.state", int'(state), 3);
    check("over.lives", int'(lives), 0);
    tick();
    check("over_hold.state", int'(state), 3);

    pulse_serve();
    tick();
    check("restart.state", int'(state), 0);
    check("restart.lives", int'(lives), 3);
    check("restart.score", int'(score), 0);

    pulse_serve();
    tick();
    check_ball("serve4", 430, 436);
    tick();
    check_ball("serve4_step", 432, 434);
    hold_hit(2);
    tick();
    check("pre_rst.score", int'(score), 1);
    check("pre_rst.state", int'(state), 1);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst.state", int'(state), 0);
    check("arst.lives", int'(lives), 3);
    check("arst.score", int'(score), 0);
    check_ball("arst.ball", 295, 436);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Game sequencer for Breakout. It owns the ball position and direction, the lives and score counters, and the serve/play/lost/game-over state machine. It sits between the VGA timing block, which supplies `frame_tick`, and the object renderers. Those renderers (paddle, wall, bricks) consume its ball position and feed back `paddle_x` and `brick_hit`. All game state advances once per video frame.

## Interface
Parameters:
- SPEED, 2: ball step per frame, in pixels, on each axis.
- LIVES, 3: lives loaded at reset and on restart. Range 1..7.
- LOST_FRAMES, 60: frames spent in LOST before leaving it. Range 1..255.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- frame_tick  input  1  one-cycle pulse per frame, issued at the start of vertical blanking.
- serve  input  1  one-cycle pulse from the button debouncer (pressed state).
- paddle_x  input  10  left column of the paddle. The paddle spans paddle_x..paddle_x+64.
- brick_hit  input  1  asserted on any cycle the scanned ball overlaps a live brick.
- ball_x  output  10  ball left column. The ball is 4×4 px.
- ball_y  output  9  ball top row.
- state  output  2  IDLE=0, PLAY=1, LOST=2, OVER=3.
- lives  output  3  remaining lives.
- score  output  10  bricks hit. Saturates at 1023.

## Operation
- Play area: columns 40..589, rows 30..479. The paddle occupies rows 440..459.
- Direction is held as dx (1 = right) and dy (1 = down).
- Internal flags:
  - serve_pend: set by `serve`.
  - hit_pend: set by `brick_hit` while in PLAY.
  - Both clear on every `frame_tick`.
- All state, position and counter updates occur only on `frame_tick` cycles.

State machine, evaluated on each `frame_tick`:
- IDLE:
  - Ball rides the paddle: ball_x = paddle_x+30, ball_y = 436, dx=1, dy=0.
  - If serve_pend: go to PLAY. The ball does not move on this tick.
- PLAY:
  - If hit_pend: invert dy and increment score (saturating) before stepping.
  - Then compute nx = ball_x ± SPEED and ny = ball_y ± SPEED, using 11-bit signed intermediates.
  - Left wall: nx < 40 → ball_x=40, dx=1.
  - Right wall: nx > 586 → ball_x=586, dx=0.
  - Top wall: ny < 30 → ball_y=30, dy=1.
  - Paddle: dy=1, ball_y+3 < 440, ny+3 ≥ 440, ball_x+3 ≥ paddle_x and ball_x ≤ paddle_x+64 → ball_y=436, dy=0.
  - Miss: ny > 476 → lives−1, load frame counter with LOST_FRAMES, go to LOST.
  - Otherwise ball_x=nx, ball_y=ny.
  - X and Y collisions are resolved independently on the same tick.
- LOST:
  - Ball is frozen. The counter decrements each tick.
  - On reaching 0: go to OVER if lives==0, else go to IDLE.
- OVER:
  - Ball is frozen.
  - If serve_pend: lives=LIVES, score=0, go to IDLE.
- `serve` is ignored in PLAY and LOST; serve_pend is simply cleared at the next tick.

## Timing
- Reset values (asynchronous):
  - state=IDLE, lives=LIVES, score=0.
  - ball_x=295, ball_y=436, dx=1, dy=0.
  - Flags=0, frame counter=0.
- Outputs are registered and change exactly one cycle after the `frame_tick` edge. They are stable for the rest of the frame.
- A `serve` or `brick_hit` arriving on the same cycle as `frame_tick` is not counted for that tick. It is lost, because the flags clear on that tick.
- A deassertion of reset_n mid-frame returns the block to reset values immediately. Operation resumes at the next `frame_tick` after release.
- `lives` never underflows: a miss with lives==1 gives lives=0, then OVER after LOST.
- Multiple `brick_hit` cycles within one frame count as one hit.

## Test plan
- Reset then serve: release reset_n with paddle_x=265, pulse serve, then apply 2 ticks.
  - After the 1st tick: state=PLAY, ball=(295,436).
  - After the 2nd tick: ball=(297,434).
- Wall bounces:
  - Left: ball at (41,100), dx=0, one tick → ball_x=40, dx=1.
  - Right: ball at (585,...), dx=1 → ball_x=586, dx=0.
  - Top: ball_y=31, dy=0 → ball_y=30, dy=1.
- Paddle catch and miss:
  - Ball at (300,435), dy=1, paddle_x=280, one tick → ball_y=436, dy=0.
  - Same with paddle_x=400 → state=LOST, lives decremented.
- Brick: assert brick_hit for 5 cycles mid-frame with the ball at (200,200), dy=0, then tick → dy=1, ball_y=202, score=1.
- Game over and restart:
  - With lives=1, miss, then 60 ticks → state=OVER, lives=0.
  - Serve plus tick → IDLE, lives=3, score=0.
- Async reset mid-PLAY: drop reset_n between ticks → all outputs return to reset values in the same cycle, with no clock edge needed.
